// File: rtl/hazard_scoreboard.sv
// Issue-gating hazard unit: tracks in-flight destination registers through a
// DEPTH-stage scoreboard and holds the front end after taken branches/returns.
module hazard_scoreboard #(
  parameter int NREG        = 16,
  parameter int DEPTH       = 3,
  parameter int NSRC        = 3,
  parameter int DS_REG      = 14,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16,
  localparam int REG_W      = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [NSRC*REG_W-1:0]  issue_src,
  input  logic [NSRC-1:0]        issue_src_en,
  input  logic                   issue_dsreg,
  input  logic [REG_W-1:0]       issue_rd,
  input  logic                   issue_wr,
  input  logic                   issue_ret,
  input  logic                   issue_branch,
  input  logic                   issue_call,
  input  logic                   pc_update,
  output logic                   issue_accept,
  output logic                   data_hazard,
  output logic                   pc_hazard,
  output logic                   stall,
  output logic [NREG-1:0]        busy_mask,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam logic [REG_W-1:0] DS_TAG  = REG_W'(DS_REG);
  localparam logic             ZERO_EX = (ZERO_REG_EN != 0);

  typedef enum logic {IDLE, CTRL_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [DEPTH:1]         sb_valid_reg;
  logic [REG_W-1:0]       sb_tag_reg [1:DEPTH];
  logic                   sb_valid_next;
  logic [REG_W-1:0]       src_eff [NSRC];
  logic [NSRC*DEPTH-1:0]  hit_mat;
  logic [CNT_W-1:0]       stall_cnt_reg;
  logic                   redirect;

  // Scoreboard head: stalled cycles naturally insert a bubble because
  // issue_accept is low.
  assign sb_valid_next = issue_accept & issue_wr &
                         !(ZERO_EX && (issue_rd == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_reg[1] <= 1'b0;
      sb_tag_reg[1]   <= '0;
    end else begin
      sb_valid_reg[1] <= sb_valid_next;
      sb_tag_reg[1]   <= issue_rd;
    end
  end

  generate
    for (genvar gi = 2; gi <= DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          sb_valid_reg[gi] <= 1'b0;
          sb_tag_reg[gi]   <= '0;
        end else begin
          sb_valid_reg[gi] <= sb_valid_reg[gi-1];
          sb_tag_reg[gi]   <= sb_tag_reg[gi-1];
        end
      end
    end
  endgenerate

  // Source 0 may be redirected to the data-segment register.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      if (gi == 0) begin : g_src0
        assign src_eff[gi] = issue_dsreg ? DS_TAG : issue_src[0 +: REG_W];
      end else begin : g_srcn
        assign src_eff[gi] = issue_src[gi*REG_W +: REG_W];
      end
      for (genvar gk = 1; gk <= DEPTH; gk++) begin : g_cmp
        assign hit_mat[gi*DEPTH + gk - 1] =
          issue_src_en[gi] && sb_valid_reg[gk] &&
          (sb_tag_reg[gk] == src_eff[gi]) &&
          !(ZERO_EX && (src_eff[gi] == '0));
      end
    end
  endgenerate

  assign data_hazard  = issue_valid & (|hit_mat);
  assign pc_hazard    = (state_reg == CTRL_WAIT);
  assign stall        = data_hazard | pc_hazard;
  assign issue_accept = issue_valid & !stall;

  always_comb begin
    busy_mask = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (sb_valid_reg[k]) busy_mask[sb_tag_reg[k]] = 1'b1;
    end
  end

  // A call is a linked jump whose target is known at issue, so it never
  // waits for the PC-update logic even if decode also flags it as a branch.
  assign redirect = (issue_ret | issue_branch) & !issue_call;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (issue_accept && redirect) state_next = CTRL_WAIT;
      CTRL_WAIT: if (pc_update) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (issue_valid && stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline's combinational hazard detector: an in-flight-write scoreboard plus control-hazard FSM that decides, each cycle, whether the instruction in IF/ID may issue into ID/EX. It tracks destination registers of issued instructions through a DEPTH-stage shift pipeline, stalls dependent instructions until the producer retires, holds the front end after taken branches/returns until the PC-update logic reports a new target, and counts stall cycles for performance monitoring. It sits between IF/ID and ID/EX, driving the pipe's stall/bubble control.

## Interface
- NREG, 16: architectural register count; REG_W = $clog2(NREG)
- DEPTH, 3: stages from issue to writeback-visible (ID/EX, EX/MEM, MEM/WB), ≥1
- NSRC, 3: source operands compared per instruction
- DS_REG, 14: data-segment register substituted for source 0 when issue_dsreg
- ZERO_REG_EN, 1: when 1, register 0 never creates or matches a hazard
- CNT_W, 16: stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  IF/ID holds a valid instruction
- issue_src  in  NSRC*REG_W  source register indices, source i at [i*REG_W +: REG_W]
- issue_src_en  in  NSRC  per-source compare enable
- issue_dsreg  in  1  source 0 replaced by DS_REG
- issue_rd  in  REG_W  destination register
- issue_wr  in  1  instruction writes issue_rd
- issue_ret, issue_branch, issue_call  in  1 each  return / taken branch / call
- pc_update  in  1  PC-update logic has produced new target
- issue_accept  out  1  instruction issues this cycle
- data_hazard  out  1  RAW hazard vs. in-flight write
- pc_hazard  out  1  control hold active
- stall  out  1  data_hazard | pc_hazard
- busy_mask  out  NREG  bit r set iff register r has an in-flight write
- stall_cnt  out  CNT_W  saturating count of cycles with issue_valid & stall

## Operation
- Scoreboard: entries sb[1..DEPTH], each {valid, tag[REG_W]}. Every cycle sb[k] <= sb[k-1] for k≥2; sb[1] <= {issue_accept & issue_wr & !(ZERO_REG_EN & issue_rd==0), issue_rd}. A stalled cycle inserts a bubble (valid=0) into sb[1].
- Effective source 0 = DS_REG if issue_dsreg else issue_src[0].
- data_hazard = issue_valid & OR over enabled sources i and valid entries k of (src_i == sb[k].tag), with src_i==0 excluded when ZERO_REG_EN. Combinational from registered state; no X-masking — all state resets to known values.
- Control FSM: IDLE, CTRL_WAIT. IDLE→CTRL_WAIT when issue_accept & (issue_ret | issue_branch). CTRL_WAIT→IDLE when pc_update. issue_call does not enter CTRL_WAIT. pc_hazard = (state == CTRL_WAIT).
- issue_accept = issue_valid & !stall. Control instructions blocked by a data hazard do not enter CTRL_WAIT until accepted.
- pc_update in IDLE: ignored.
- busy_mask = OR of one-hot(sb[k].tag) over valid k.
- stall_cnt increments when issue_valid & stall, saturates at all-ones.

## Timing
- Reset: all sb valid=0, state IDLE, stall_cnt=0; hence data_hazard=0, pc_hazard=0, stall=0, busy_mask=0, issue_accept=issue_valid. rst mid-operation discards all in-flight entries and any CTRL_WAIT in the same edge.
- Producer accepted cycle t: its rd is in busy_mask cycles t+1..t+DEPTH, clear at t+DEPTH+1. A dependent instruction presented at t+1 stalls DEPTH cycles, is accepted at t+DEPTH+1.
- Branch/ret accepted cycle t: pc_hazard=1 from t+1; pc_update at cycle u clears it for u+1 (issue possible at u+1). pc_update at t+1 gives one stall cycle.
- Simultaneous data and control hazard: stall=1, both flags reported independently.
- Zero issue latency when no hazard: issue_accept same cycle as issue_valid.

## Test plan
- Reset: assert rst 2 cycles with issue_valid=1 → all outputs 0 except issue_accept=1, stall_cnt=0.
- RAW, DEPTH=3: cycle 0 issue wr r5; cycle 1 present src0=r5 → data_hazard=1 cycles 1–3, accept at cycle 4, busy_mask=0x0020 cycles 1–3, stall_cnt=3.
- DataReg + zero reg: in-flight writes r14 and r0; instruction with issue_dsreg=1 stalls on r14; instruction reading only r0 never stalls; r0 never in busy_mask.
- Return: accept issue_ret at cycle 0, pc_update at cycle 4 → pc_hazard=1 cycles 1–4, 0 at 5; call instead → pc_hazard never asserts.
- Back-to-back independent writes r1,r2,r3 cycles 0–2 → no stalls, busy_mask=0x000E at cycle 3, 0x0000 at cycle 6.
- Saturation/reset mid-op: CNT_W=2, hold hazard 6 cycles → stall_cnt sticks at 3; rst during CTRL_WAIT → pc_hazard=0 next cycle.
